// File: rtl/jtkiwi_shram_pkg.sv
// Shared types and constants for the Kiwi main/sub shared-RAM arbiter.
package jtkiwi_shram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMainAddr,
    StMainData,
    StSubAddr,
    StSubData
  } state_e;

  localparam int unsigned SLOT_LEN   = 2;
  localparam logic        GRANT_MAIN = 1'b1;
  localparam logic        GRANT_SUB  = 1'b0;

endpackage

// File: rtl/jtframe_ram.sv
// Single-port synchronous RAM with registered read data (read-before-write).
module jtframe_ram #(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic          we,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data;
    q <= mem[addr];
  end

endmodule

// File: rtl/jtkiwi_shram.sv
// Main/sub CPU shared-RAM arbiter with 2-clk slots and alternating tie-break.
// Optional JTKIWI_SHRAM_CNT_EN adds a saturating collision counter port coll_cnt.
module jtkiwi_shram
  import jtkiwi_shram_pkg::*;
#(
  parameter int unsigned AW        = 13,
  parameter bit          MAIN_PRIO = 1'b1
) (
  input  logic          rst_n,
  input  logic          clk,
  input  logic [AW-1:0] main_addr,
  input  logic [7:0]    main_dout,
  input  logic          main_rnw,
  input  logic          main_cs,
  output logic [7:0]    main_din,
  output logic          main_busy,
  input  logic [AW-1:0] snd_addr,
  input  logic [7:0]    snd_dout,
  input  logic          snd_rnw,
  input  logic          snd_cs,
  output logic [7:0]    snd_din,
  output logic          mshramen
`ifdef JTKIWI_SHRAM_CNT_EN
  ,
  output logic [15:0]   coll_cnt
`endif
);

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          served_main_q, served_snd_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdata_q;
  logic          wr_q;
  logic [7:0]    ram_q;
  logic          ram_we;
  logic          pend_main, pend_snd;

  assign pend_main = main_cs & ~served_main_q;
  assign pend_snd  = snd_cs & ~served_snd_q;

  // Gated by rst_n so both stalls drop the instant reset is asserted.
  assign main_busy = rst_n & pend_main & (state_q != StMainData);
  assign mshramen  = rst_n & pend_snd & (state_q != StSubData);

  assign ram_we = wr_q & ((state_q == StMainAddr) | (state_q == StSubAddr));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      StIdle: begin
        if (pend_main && (!pend_snd || last_grant_q == GRANT_SUB)) begin
          state_d      = StMainAddr;
          last_grant_d = GRANT_MAIN;
        end else if (pend_snd) begin
          state_d      = StSubAddr;
          last_grant_d = GRANT_SUB;
        end
      end
      StMainAddr: state_d = StMainData;
      StMainData: state_d = StIdle;
      StSubAddr:  state_d = StSubData;
      StSubData:  state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      last_grant_q  <= MAIN_PRIO ? GRANT_SUB : GRANT_MAIN;
      served_main_q <= 1'b0;
      served_snd_q  <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wr_q          <= 1'b0;
      main_din      <= '0;
      snd_din       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      // A served flag only survives while cs stays high, so each cs pulse is served once.
      served_main_q <= main_cs & (served_main_q | (state_q == StMainData));
      served_snd_q  <= snd_cs & (served_snd_q | (state_q == StSubData));
      if (state_d == StMainAddr && state_q == StIdle) begin
        addr_q  <= main_addr;
        wdata_q <= main_dout;
        wr_q    <= ~main_rnw;
      end else if (state_d == StSubAddr && state_q == StIdle) begin
        addr_q  <= snd_addr;
        wdata_q <= snd_dout;
        wr_q    <= ~snd_rnw;
      end
      // Read data is dropped if the requester abandoned the slot.
      if (state_q == StMainData && main_cs && !wr_q) main_din <= ram_q;
      if (state_q == StSubData && snd_cs && !wr_q) snd_din <= ram_q;
    end
  end

`ifdef JTKIWI_SHRAM_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_cnt <= '0;
    end else if (state_q == StIdle && pend_main && pend_snd && coll_cnt != 16'hffff) begin
      coll_cnt <= coll_cnt + 16'd1;
    end
  end
`endif

  jtframe_ram #(
    .AW(AW),
    .DW(8)
  ) u_ram (
    .clk  (clk),
    .addr (addr_q),
    .data (wdata_q),
    .we   (ram_we),
    .q    (ram_q)
  );

endmodule
